// File: rtl/pkt_checksum_append.sv
// Stream pass-through that appends a two's-complement checksum beat to every packet,
// so the output bytes of each packet sum to zero. It also checks packet length and counts delivered packets.
module pkt_checksum_append #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic [7:0]            exp_len,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  len_err,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    typedef enum logic {
        PASS   = 1'b0,
        APPEND = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [7:0]            exp_len_q, exp_len_d;
    logic                  len_err_q, len_err_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;

    logic                  out_free;
    logic                  in_fire;
    logic                  out_fire;
    logic [7:0]            beat_cnt_inc;
    logic [7:0]            exp_len_cur;
    logic [DATA_WIDTH-1:0] sum_next;

    assign out_free      = !tvalid_q || m_axis_tready;
    assign s_axis_tready = (state_q == PASS) && out_free && !rst;
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = tvalid_q && m_axis_tready;
    assign beat_cnt_inc  = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
    // A zero beat count marks the first beat, so exp_len is taken live only then.
    assign exp_len_cur   = (beat_cnt_q == 8'd0) ? exp_len : exp_len_q;
    assign sum_next      = sum_q + s_axis_tdata;

    always_comb begin
        state_d     = state_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        sum_d       = sum_q;
        chk_d       = chk_q;
        beat_cnt_d  = beat_cnt_q;
        exp_len_d   = exp_len_q;
        len_err_d   = 1'b0;
        pkt_count_d = pkt_count_q;

        if (out_fire && tlast_q) begin
            pkt_count_d = pkt_count_q + CNT_ONE;
        end

        case (state_q)
            PASS: begin
                if (in_fire) begin
                    tdata_d    = s_axis_tdata;
                    tvalid_d   = 1'b1;
                    tlast_d    = 1'b0;
                    sum_d      = sum_next;
                    beat_cnt_d = beat_cnt_inc;
                    exp_len_d  = exp_len_cur;
                    if (s_axis_tlast) begin
                        chk_d     = '0 - sum_next;
                        len_err_d = (exp_len_cur != 8'd0) && (beat_cnt_inc != exp_len_cur);
                        state_d   = APPEND;
                    end
                end else if (out_free) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end
            end
            APPEND: begin
                if (out_free) begin
                    tdata_d    = chk_q;
                    tvalid_d   = 1'b1;
                    tlast_d    = 1'b1;
                    sum_d      = '0;
                    beat_cnt_d = 8'd0;
                    state_d    = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PASS;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            sum_q       <= '0;
            chk_q       <= '0;
            beat_cnt_q  <= 8'd0;
            exp_len_q   <= 8'd0;
            len_err_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            sum_q       <= sum_d;
            chk_q       <= chk_d;
            beat_cnt_q  <= beat_cnt_d;
            exp_len_q   <= exp_len_d;
            len_err_q   <= len_err_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign len_err       = len_err_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_pkt_checksum_append.sv
// Bench for pkt_checksum_append: directed vectors plus random packets against a
// packet-level model (byte queues, checksum from the packet sum, length rule).
module tb_pkt_checksum_append;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [7:0]  exp_len;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        len_err;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    pkt_checksum_append #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .exp_len       (exp_len),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .len_err       (len_err),
        .pkt_count     (pkt_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Model state: expected output words are {last, data}.
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    logic [7:0] cur_bytes[$];
    logic [7:0] cur_exp_len;
    int         exp_pkt = 0;
    int         err_pulses = 0;
    bit         pending_err = 0;
    bit         rst_seen = 0;
    bit         hold_valid = 0;
    logic [8:0] hold_word;
    int         sum;
    int         nbeats;

    always @(posedge clk) rst_seen <= rst;

    always @(negedge clk) begin
        if (rst) begin
            check("rdy_in_rst", {31'd0, s_tready}, 32'd0);
            if (rst_seen) begin
                check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
                check("rst_tlast", {31'd0, m_tlast}, 32'd0);
                check("rst_tdata", {24'd0, m_tdata}, 32'd0);
                check("rst_len_err", {31'd0, len_err}, 32'd0);
                check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
            end
            exp_q.delete();
            obs_q.delete();
            cur_bytes.delete();
            exp_pkt     = 0;
            pending_err = 0;
            hold_valid  = 0;
        end else begin
            check("len_err", {31'd0, len_err}, {31'd0, pending_err});
            if (len_err) err_pulses++;
            check("pkt_count", {16'd0, pkt_count}, exp_pkt % 65536);
            if (hold_valid) begin
                check("hold_valid", {31'd0, m_tvalid}, 32'd1);
                check("hold_word", {23'd0, m_tlast, m_tdata}, {23'd0, hold_word});
            end
            if (m_tvalid && !m_tready) check("rdy_stall", {31'd0, s_tready}, 32'd0);
            hold_valid  = m_tvalid && !m_tready;
            hold_word   = {m_tlast, m_tdata};
            pending_err = 0;
            if (s_tvalid && s_tready) begin
                if (cur_bytes.size() == 0) cur_exp_len = exp_len;
                cur_bytes.push_back(s_tdata);
                exp_q.push_back({1'b0, s_tdata});
                if (s_tlast) begin
                    sum = 0;
                    foreach (cur_bytes[k]) sum += int'(cur_bytes[k]);
                    nbeats = cur_bytes.size();
                    exp_q.push_back({1'b1, 8'((256 - (sum % 256)) % 256)});
                    if (nbeats > 255) nbeats = 255;
                    pending_err = (cur_exp_len != 8'd0) && (nbeats != int'(cur_exp_len));
                    cur_bytes.delete();
                end
            end
            if (m_tvalid && m_tready) begin
                obs_q.push_back({m_tlast, m_tdata});
                check("out_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) check("out_beat", {23'd0, m_tlast, m_tdata}, {23'd0, exp_q.pop_front()});
                if (m_tlast) exp_pkt++;
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = two-cycle stall after 2nd output beat.
    int tr_mode = 0;
    int stall_left = 0;
    bit stall_done = 0;
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0: m_tready = 1'b1;
                1: m_tready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!stall_done && obs_q.size() == 2) begin
                        stall_left = 2;
                        stall_done = 1;
                    end
                    if (stall_left > 0) begin
                        m_tready = 1'b0;
                        stall_left--;
                    end else begin
                        m_tready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last);
        int guard = 0;
        bit acc = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!acc && guard < 300) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            guard++;
        end
        check("in_accept", {31'd0, acc}, 32'd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] bytes[$], input logic [7:0] el, input bit gaps);
        exp_len = el;
        for (int i = 0; i < bytes.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_beat(bytes[i], i == bytes.size() - 1);
            exp_len = 8'($urandom);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || m_tvalid) && guard < 1000) begin
            idle(1);
            guard++;
        end
        check("drain", {31'd0, exp_q.size() == 0}, 32'd1);
        idle(2);
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rst      = 1'b1;
        idle(3);
        rst = 1'b0;
        err_pulses = 0;
        stall_done = 0;
    endtask

    task automatic expect_stream(input string tag, input logic [8:0] want[$]);
        check({tag, "_len"}, obs_q.size(), want.size());
        for (int i = 0; i < want.size() && i < obs_q.size(); i++)
            check(tag, {23'd0, obs_q[i]}, {23'd0, want[i]});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] p[$];
        logic [8:0] w[$];
        int         len;
        rst      = 1'b1;
        s_tdata  = 8'd0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        exp_len  = 8'd0;
        do_reset();

        // Basic 3-beat packet with correct length.
        p = {8'h01, 8'h02, 8'h03};
        send_pkt(p, 8'd3, 0);
        drain();
        w = {9'h001, 9'h002, 9'h003, 9'h1FA};
        expect_stream("t_basic", w);
        check("t_basic_err", err_pulses, 0);
        check("t_basic_cnt", {16'd0, pkt_count}, 32'd1);

        // Single-beat packet.
        do_reset();
        p = {8'h80};
        send_pkt(p, 8'd1, 0);
        drain();
        w = {9'h080, 9'h180};
        expect_stream("t_single", w);
        check("t_single_cnt", {16'd0, pkt_count}, 32'd1);

        // Downstream stall after the second output beat.
        do_reset();
        tr_mode = 2;
        p = {8'h10, 8'h11, 8'h12, 8'h13};
        send_pkt(p, 8'd0, 0);
        drain();
        w = {9'h010, 9'h011, 9'h012, 9'h013, 9'h1BA};
        expect_stream("t_stall", w);
        check("t_stall_done", {31'd0, stall_done}, 32'd1);
        tr_mode = 0;

        // Short packet against exp_len=4.
        do_reset();
        p = {8'h05, 8'h06};
        send_pkt(p, 8'd4, 0);
        drain();
        w = {9'h005, 9'h006, 9'h1F5};
        expect_stream("t_lenerr", w);
        check("t_lenerr_pulses", err_pulses, 1);

        // Back-to-back packets.
        do_reset();
        p = {8'hFF, 8'hFF};
        send_pkt(p, 8'd0, 0);
        p = {8'h00};
        send_pkt(p, 8'd0, 0);
        drain();
        w = {9'h0FF, 9'h0FF, 9'h102, 9'h000, 9'h100};
        expect_stream("t_b2b", w);
        check("t_b2b_cnt", {16'd0, pkt_count}, 32'd2);

        // Reset in the middle of a packet discards it.
        send_beat(8'h11, 0);
        send_beat(8'h22, 0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("t_rst_cnt", {16'd0, pkt_count}, 32'd0);
        check("t_rst_valid", {31'd0, m_tvalid}, 32'd0);
        p = {8'h01};
        send_pkt(p, 8'd0, 0);
        drain();
        w = {9'h001, 9'h1FF};
        expect_stream("t_rst", w);
        check("t_rst_cnt2", {16'd0, pkt_count}, 32'd1);

        // Beat counter saturation: 257 beats against exp_len=255 is not an error.
        do_reset();
        p.delete();
        for (int i = 0; i < 257; i++) p.push_back(8'($urandom));
        send_pkt(p, 8'd255, 0);
        drain();
        check("t_sat_err", err_pulses, 0);
        check("t_sat_len", obs_q.size(), 258);

        // Random packets, random gaps, random downstream ready.
        do_reset();
        tr_mode = 1;
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(1, 6);
            p.delete();
            for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            case ($urandom_range(0, 2))
                0: send_pkt(p, 8'd0, 1);
                1: send_pkt(p, 8'(len), 1);
                default: send_pkt(p, 8'($urandom_range(1, 8)), 1);
            endcase
        end
        tr_mode = 0;
        drain();
        check("t_rand_cnt", {16'd0, pkt_count}, 32'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_checksum_append.md
PKT_CHECKSUM_APPEND -- requirements
Module: pkt_checksum_append

Interface
REQ-001: The block SHALL have parameter DATA_WIDTH, default 8, giving the byte width of both streams.
REQ-002: The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the packet counter.
REQ-003: clk  input  1  clock; all logic SHALL be rising-edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: s_axis_tdata  input  DATA_WIDTH  upstream packet byte.
REQ-006: s_axis_tvalid  input  1  upstream beat valid.
REQ-007: s_axis_tlast  input  1  upstream last beat of packet.
REQ-008: s_axis_tready  output  1  block accepts the upstream beat this cycle.
REQ-009: exp_len  input  8  expected data-beat count per packet; 0 disables length checking.
REQ-010: m_axis_tdata  output  DATA_WIDTH  data byte or appended checksum byte.
REQ-011: m_axis_tvalid  output  1  output beat valid.
REQ-012: m_axis_tlast  output  1  asserted only on the appended checksum beat.
REQ-013: m_axis_tready  input  1  downstream accepts the output beat.
REQ-014: len_err  output  1  one-cycle pulse on a packet length mismatch.
REQ-015: pkt_count  output  CNT_WIDTH  count of packets fully delivered downstream.

Function
REQ-016: Beat transfer SHALL occur on a stream only when tvalid and tready are both high in the same cycle.
REQ-017: The output SHALL be a single register stage (m_axis_tdata/tvalid/tlast); the register is "free" when m_axis_tvalid=0 or m_axis_tready=1.
REQ-018: The state machine SHALL have two states: PASS and APPEND; reset state is PASS.
REQ-019: s_axis_tready SHALL equal (state==PASS) and the output register is free; it is combinational.
REQ-020: In PASS, an accepted input beat SHALL be loaded into the output register next edge with tvalid=1 and tlast=0; latency is 1 cycle.
REQ-021: The running sum SHALL be an 8-bit modulo-256 sum of the packet's data bytes, cleared at packet end.
REQ-022: On an accepted beat with s_axis_tlast=1, the block SHALL latch chk = (256 - ((sum + s_axis_tdata) mod 256)) mod 256 and go to APPEND.
REQ-023: In APPEND, once the output register is free, the block SHALL load chk with tvalid=1 and tlast=1, clear sum and beat counter, and return to PASS.
REQ-024: If the output register is not free, its contents SHALL be held unchanged; no beat is ever dropped or duplicated.
REQ-025: If the output register is free and no beat is loaded into it, m_axis_tvalid SHALL go to 0 on the next edge.
REQ-026: An N-beat input packet SHALL therefore produce N+1 output beats; sum of all output bytes mod 256 equals 0.
REQ-027: exp_len SHALL be sampled on the first accepted beat of each packet and held for that packet.
REQ-028: An 8-bit beat counter SHALL count accepted beats per packet and saturate at 255.
REQ-029: On the accepted tlast beat, if sampled exp_len!=0 and (count+1, saturated at 255) != exp_len, len_err SHALL pulse high for exactly the next cycle; otherwise it stays 0.
REQ-030: pkt_count SHALL increment by 1 when an output beat with m_axis_tlast=1 is accepted, wrapping at 2^CNT_WIDTH.
REQ-031: A single-beat packet (tvalid and tlast on the first beat) SHALL be legal and produce 2 output beats.
REQ-032: Back-to-back packets SHALL be accepted with zero idle cycles beyond the one cycle spent in APPEND.

Reset
REQ-033: While rst=1: state=PASS, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, len_err=0, pkt_count=0, sum=0, beat counter=0, chk=0.
REQ-034: s_axis_tready SHALL be 0 while rst=1.
REQ-035: Reset asserted mid-packet SHALL discard the partial packet; the first beat after reset starts a new packet.

Verification
REQ-036: exp_len=3, input 0x01,0x02,0x03 (tlast on 0x03), m_axis_tready=1 -> output 0x01,0x02,0x03,0xFA with tlast only on 0xFA; len_err=0; pkt_count=1.
REQ-037: Single beat 0x80 with tlast, exp_len=1 -> output 0x80 then 0x80 (tlast); pkt_count increments by 1.
REQ-038: 4-beat packet 0x10..0x13, m_axis_tready low 2 cycles after the second output beat -> output held stable, s_axis_tready=0 while stalled, final stream 0x10,0x11,0x12,0x13,0xBA.
REQ-039: exp_len=4, input 2 beats 0x05,0x06 (tlast) -> output 0x05,0x06,0xF5; len_err pulses high for exactly 1 cycle.
REQ-040: Two packets back-to-back {0xFF,0xFF} and {0x00} -> output 0xFF,0xFF,0x02(last),0x00,0x00(last); pkt_count=2.
REQ-041: rst pulsed after 2 beats of a 5-beat packet -> all outputs return to reset values; next packet {0x01} yields 0x01,0xFF(last) with pkt_count=1.
